// File: rtl/memory_access_pkg.sv
//------------------------------------------------------------------------------
// memory_access_pkg
// Shared writeback-source codes, load/store funct3 codes, M-stage FSM states
// and access-size helpers.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package memory_access_pkg;

    localparam logic [1:0] RDSRC_ALU = 2'd0;
    localparam logic [1:0] RDSRC_MEM = 2'd1;
    localparam logic [1:0] RDSRC_PC4 = 2'd2;
    localparam logic [1:0] RDSRC_CSR = 2'd3;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_ADDR = 2'd1,
        MEM_RESP = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_e;

    // log2 of the access size in bytes; codes not defined for the op act as a word access
    function automatic logic [1:0] access_log2size(input logic is_store, input logic [2:0] f3);
        logic [1:0] lg;
        lg = 2'd2;
        if (is_store) begin
            case (f3)
                FUNCT3_B: lg = 2'd0;
                FUNCT3_H: lg = 2'd1;
                default:  lg = 2'd2;
            endcase
        end else begin
            case (f3)
                FUNCT3_B, FUNCT3_BU: lg = 2'd0;
                FUNCT3_H, FUNCT3_HU: lg = 2'd1;
                default:             lg = 2'd2;
            endcase
        end
        return lg;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] lg, input logic [1:0] a);
        logic mis;
        case (lg)
            2'd0:    mis = 1'b0;
            2'd1:    mis = a[0];
            default: mis = |a;
        endcase
        return mis;
    endfunction

endpackage

`default_nettype wire

// File: rtl/memory_access_lsu_align.sv
//------------------------------------------------------------------------------
// lsu_align
// Combinational store lane/byte-enable generation and load extract/extend.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lsu_align
    import memory_access_pkg::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [1:0]  w_lg;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unsigned;

    assign w_lg       = access_log2size(i_is_store, i_funct3);
    assign w_half     = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign w_unsigned = (i_funct3 == FUNCT3_BU) || (i_funct3 == FUNCT3_HU);

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    always_comb begin
        o_be        = 4'hF;
        o_wdata     = i_store_data;
        o_load_data = i_rdata;
        case (w_lg)
            2'd0: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = w_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            2'd1: begin
                o_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata     = {2{i_store_data[15:0]}};
                o_load_data = w_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: begin
                o_be        = 4'hF;
                o_wdata     = i_store_data;
                o_load_data = i_rdata;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/memory_access.sv
//------------------------------------------------------------------------------
// memory_access
// M pipeline stage: registers execute results, runs the data-memory bus
// transaction, aligns load data and presents results to writeback.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module memory_access
    import memory_access_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write_e,
    input  logic        rd_write_e,
    input  logic [1:0]  rd_write_src_e,
    input  logic        mem_write_e,
    input  logic [2:0]  mem_funct3_e,
    input  logic [4:0]  rd_e,
    input  logic [31:0] pc_e,
    input  logic [31:0] alu_res_e,
    input  logic [31:0] mem_data_e,
    input  logic [31:0] csr_data_e,
    input  logic        flush_m,
    output logic        pc_write_m,
    output logic        rd_write_m,
    output logic [1:0]  rd_write_src_m,
    output logic [4:0]  rd_m,
    output logic [31:0] pc_m,
    output logic [31:0] alu_res_m,
    output logic [31:0] csr_data_m,
    output logic [31:0] load_data_m,
    output logic        stall_m,
    output logic        misaligned_m,
    output logic        bus_err_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam logic [31:0] c_tmo = DMEM_TIMEOUT;

    logic        r_pc_write;
    logic        r_rd_write;
    logic [1:0]  r_rd_write_src;
    logic [4:0]  r_rd;
    logic [31:0] r_pc;
    logic [31:0] r_alu_res;
    logic [31:0] r_csr_data;
    logic        r_mem_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_store_data;
    logic [31:0] r_load_data;
    logic        r_misaligned;
    logic        r_bus_err;
    logic [31:0] r_tmo_cnt;
    mem_state_e  r_state;

    logic        w_stall;
    logic        w_req;
    logic        w_mem_op_e;
    logic        w_mis_e;
    logic        w_tmo_hit;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_ext;

    assign w_mem_op_e = mem_write_e | (rd_write_src_e == RDSRC_MEM);
    assign w_mis_e    = w_mem_op_e &
                        is_misaligned(access_log2size(mem_write_e, mem_funct3_e), alu_res_e[1:0]);
    assign w_stall    = (r_state == MEM_ADDR) || (r_state == MEM_RESP);
    assign w_req      = (r_state == MEM_ADDR);
    // The access is aborted on the edge that closes its DMEM_TIMEOUT-th stalled cycle
    assign w_tmo_hit  = (c_tmo != 32'd0) && ((r_tmo_cnt + 32'd1) == c_tmo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_write     <= 1'b0;
            r_rd_write     <= 1'b0;
            r_rd_write_src <= RDSRC_ALU;
            r_rd           <= '0;
            r_pc           <= '0;
            r_alu_res      <= '0;
            r_csr_data     <= '0;
            r_mem_write    <= 1'b0;
            r_funct3       <= '0;
            r_store_data   <= '0;
            r_load_data    <= '0;
            r_misaligned   <= 1'b0;
            r_bus_err      <= 1'b0;
            r_tmo_cnt      <= '0;
            r_state        <= MEM_IDLE;
        end else if (!w_stall) begin
            r_bus_err <= 1'b0;
            r_tmo_cnt <= '0;
            if (flush_m) begin
                r_pc_write     <= 1'b0;
                r_rd_write     <= 1'b0;
                r_rd_write_src <= RDSRC_ALU;
                r_rd           <= '0;
                r_pc           <= '0;
                r_alu_res      <= '0;
                r_csr_data     <= '0;
                r_mem_write    <= 1'b0;
                r_funct3       <= '0;
                r_store_data   <= '0;
                r_misaligned   <= 1'b0;
                r_state        <= MEM_IDLE;
            end else begin
                r_pc_write     <= pc_write_e;
                r_rd_write     <= rd_write_e;
                r_rd_write_src <= rd_write_src_e;
                r_rd           <= rd_e;
                r_pc           <= pc_e;
                r_alu_res      <= alu_res_e;
                r_csr_data     <= csr_data_e;
                r_mem_write    <= mem_write_e;
                r_funct3       <= mem_funct3_e;
                r_store_data   <= mem_data_e;
                r_misaligned   <= w_mis_e;
                if (!w_mem_op_e) begin
                    r_state <= MEM_IDLE;
                end else if (w_mis_e) begin
                    r_state <= MEM_DONE;
                end else begin
                    r_state <= MEM_ADDR;
                end
            end
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
            // A bus completion in the same cycle as the timeout wins
            case (r_state)
                MEM_ADDR: begin
                    if (dmem_gnt) begin
                        r_state <= r_mem_write ? MEM_DONE : MEM_RESP;
                    end else if (w_tmo_hit) begin
                        r_state   <= MEM_DONE;
                        r_bus_err <= 1'b1;
                    end
                end
                MEM_RESP: begin
                    if (dmem_rvalid) begin
                        r_load_data <= w_load_ext;
                        r_state     <= MEM_DONE;
                    end else if (w_tmo_hit) begin
                        r_state   <= MEM_DONE;
                        r_bus_err <= 1'b1;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    lsu_align u_lsu_align (
        .i_is_store   (r_mem_write),
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_alu_res[1:0]),
        .i_store_data (r_store_data),
        .i_rdata      (dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_ext)
    );

    assign pc_write_m     = r_pc_write;
    assign rd_write_m     = r_rd_write & ~r_misaligned & ~r_bus_err;
    assign rd_write_src_m = r_rd_write_src;
    assign rd_m           = r_rd;
    assign pc_m           = r_pc;
    assign alu_res_m      = r_alu_res;
    assign csr_data_m     = r_csr_data;
    assign load_data_m    = r_load_data;
    assign stall_m        = w_stall;
    assign misaligned_m   = r_misaligned;
    assign bus_err_m      = r_bus_err;

    assign dmem_req   = w_req;
    assign dmem_we    = w_req & r_mem_write;
    assign dmem_addr  = w_req ? {r_alu_res[31:2], 2'b00} : 32'd0;
    assign dmem_be    = w_req ? w_be : 4'd0;
    assign dmem_wdata = (w_req & r_mem_write) ? w_wdata : 32'd0;

endmodule

`default_nettype wire
